// File: rtl/nibble_pair_sequencer.sv
// Collects two BYTES-byte operands over a byte stream, then issues nibble pairs
// (full schoolbook or diagonal only) with their weight to a digit-serial MAC.
`timescale 1ns/1ps
module nibble_pair_sequencer #(
  parameter int BYTES = 4,
  parameter int IDX_W = ($clog2(2*BYTES) < 1) ? 1 : $clog2(2*BYTES),
  parameter int WGT_W = ($clog2(4*BYTES-1) < 1) ? 1 : $clog2(4*BYTES-1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       dig_a,
  output logic [3:0]       dig_b,
  output logic [IDX_W-1:0] idx_a,
  output logic [IDX_W-1:0] idx_b,
  output logic [WGT_W-1:0] weight,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int NDIG  = 2*BYTES;
  localparam int OPW   = 8*BYTES;
  localparam int CNT_W = ($clog2(BYTES+1) < 1) ? 1 : $clog2(BYTES+1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NDIG-1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [OPW-1:0]     a_q, a_d, b_q, b_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   i_q, i_d, j_q, j_d;
  logic               is_last;

  assign is_last = (i_q == IDX_MAX) && (j_q == IDX_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    i_d       = i_q;
    j_d       = j_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = (a_q << 8) | OPW'(in_a);
          b_d     = (b_q << 8) | OPW'(in_b);
          mode_d  = mode;
          cnt_d   = CNT_W'(1);
          state_d = (BYTES == 1) ? S_ISSUE : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d = (a_q << 8) | OPW'(in_a);
          b_d = (b_q << 8) | OPW'(in_b);
          if (cnt_q == CNT_W'(BYTES-1)) begin
            cnt_d   = '0;
            state_d = S_ISSUE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (is_last) begin
            i_d     = '0;
            j_d     = '0;
            state_d = S_DONE;
          end else if (mode_q) begin
            i_d = i_q + 1'b1;
            j_d = j_q + 1'b1;
          end else if (j_q == IDX_MAX) begin
            i_d = i_q + 1'b1;
            j_d = '0;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything, including a byte offered in the same cycle.
    if (clear) begin
      state_d = S_IDLE;
      a_d     = '0;
      b_d     = '0;
      mode_d  = 1'b0;
      cnt_d   = '0;
      i_d     = '0;
      j_d     = '0;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign dig_a    = out_valid ? a_q[{i_q, 2'b00} +: 4] : '0;
  assign dig_b    = out_valid ? b_q[{j_q, 2'b00} +: 4] : '0;
  assign idx_a    = out_valid ? i_q : '0;
  assign idx_b    = out_valid ? j_q : '0;
  assign weight   = out_valid ? (WGT_W'(i_q) + WGT_W'(j_q)) : '0;
  assign out_last = out_valid & is_last;

endmodule

// File: tb/tb_nibble_pair_sequencer.sv
// Directed scoreboard bench for nibble_pair_sequencer (BYTES=4 and BYTES=1 builds).
`timescale 1ns/1ps
module tb_nibble_pair_sequencer;

  localparam int NDIG  = 8;
  localparam int IDX_W = 3;
  localparam int WGT_W = 4;

  logic clk = 1'b0;
  logic rst_n, clear, mode, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b;
  logic [3:0] dig_a, dig_b;
  logic [IDX_W-1:0] idx_a, idx_b;
  logic [WGT_W-1:0] weight;
  logic out_last, busy, done;

  logic s_clear, s_mode, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0] s_in_a, s_in_b;
  logic [3:0] s_dig_a, s_dig_b;
  logic [0:0] s_idx_a, s_idx_b;
  logic [1:0] s_weight;
  logic s_out_last, s_busy, s_done;

  nibble_pair_sequencer #(.BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .dig_a(dig_a), .dig_b(dig_b),
    .idx_a(idx_a), .idx_b(idx_b), .weight(weight), .out_last(out_last),
    .busy(busy), .done(done)
  );

  nibble_pair_sequencer #(.BYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(s_clear), .mode(s_mode),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .dig_a(s_dig_a), .dig_b(s_dig_b),
    .idx_a(s_idx_a), .idx_b(s_idx_b), .weight(s_weight), .out_last(s_out_last),
    .busy(s_busy), .done(s_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] da;
    logic [3:0] db;
    logic [2:0] ia;
    logic [2:0] ib;
    logic [3:0] w;
    logic       last;
  } pair_t;

  pair_t       sb[$];
  logic [12:0] sb1[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_pairs(input logic [31:0] a, input logic [31:0] b, input logic m);
    for (int i = 0; i < NDIG; i++)
      for (int j = 0; j < NDIG; j++)
        if (!m || i == j) begin
          pair_t p;
          p.da   = a[4*i +: 4];
          p.db   = b[4*j +: 4];
          p.ia   = 3'(i);
          p.ib   = 3'(j);
          p.w    = 4'(i + j);
          p.last = (i == NDIG-1) && (j == NDIG-1);
          sb.push_back(p);
        end
  endfunction

  function automatic logic [31:0] obs_pair();
    return 32'({dig_a, dig_b, idx_a, idx_b, weight, out_last});
  endfunction

  // First byte goes out first and lands most significant; mode flips after byte 0.
  task automatic load(input logic [31:0] a, input logic [31:0] b, input logic m, input bit gap);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_a     = a[31-8*k -: 8];
      in_b     = b[31-8*k -: 8];
      mode     = (k == 0) ? m : ~m;
      step();
      if (gap) begin
        in_valid = 1'b0;
        in_a     = 8'hEE;
        in_b     = 8'h11;
        step();
        if (k < 3) chk("gap_ready", 32'({in_ready, busy, out_valid}), 32'(3'b110));
      end
    end
    in_valid = 1'b0;
    push_pairs(a, b, m);
  endtask

  task automatic drain(input int n_exp, input int stall_at, input int clr_at);
    int    got = 0;
    int    cyc = 0;
    bit    fin = 1'b0;
    bit    lst;
    pair_t e;
    out_ready = 1'b1;
    while (!fin && cyc < 3000) begin
      cyc++;
      if (!out_valid) begin
        step();
      end else if (sb.size() == 0) begin
        chk("extra_pair", 32'(out_valid), 32'(0));
        fin = 1'b1;
      end else begin
        if (got == stall_at) begin
          out_ready = 1'b0;
          repeat (5) begin
            step();
            chk("stall_hold", 32'({out_valid, dig_a, dig_b, idx_a, idx_b, weight, out_last}),
                32'({1'b1, sb[0]}));
          end
          out_ready = 1'b1;
        end
        if (got == clr_at) begin
          clear = 1'b1;
          step();
          clear = 1'b0;
          chk("clear_idle", 32'({out_valid, busy, in_ready, done, dig_a, weight}), 32'(12'b0010_0000_0000));
          step();
          chk("clear_nodone", 32'({done, out_valid, busy}), 32'(0));
          sb.delete();
          fin = 1'b1;
        end else begin
          e = sb.pop_front();
          chk("pair", obs_pair(), 32'(e));
          got++;
          lst = out_last;
          step();
          if (lst) begin
            chk("done_pulse", 32'({done, out_valid, in_ready, busy}), 32'(4'b1001));
            step();
            chk("done_end", 32'({done, busy, in_ready}), 32'(3'b001));
            fin = 1'b1;
          end
        end
      end
    end
    out_ready = 1'b0;
    chk("drain_finished", 32'(fin), 32'(1));
    if (clr_at < 0) chk("pair_count", 32'(got), 32'(n_exp));
  endtask

  initial begin
    logic [31:0] A  = 32'h12345678;
    logic [31:0] B  = 32'h9ABCDEF0;
    logic [31:0] A2 = 32'hC0FFEE17;
    logic [31:0] B2 = 32'h5A3B9D04;
    int s_got;
    bit s_fin;
    bit s_lst;
    logic [7:0] sa;
    logic [7:0] sbv;
    rst_n = 1'b0; clear = 1'b0; mode = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    s_clear = 1'b0; s_mode = 1'b0; s_in_valid = 1'b0;
    s_in_a = '0; s_in_b = '0; s_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("reset_ctl", 32'({in_ready, out_valid, busy, done}), 32'(4'b1000));
    chk("reset_zero", obs_pair(), 32'(0));
    chk("reset_ctl_b1", 32'({s_in_ready, s_out_valid, s_busy, s_done}), 32'(4'b1000));

    // full schoolbook, then diagonal
    load(A, B, 1'b0, 1'b0);
    drain(64, -1, -1);
    load(A, B, 1'b1, 1'b0);
    drain(8, -1, -1);

    // backpressure at pair (2,3)
    load(A, B, 1'b0, 1'b0);
    drain(64, 19, -1);

    // in_valid gaps during load, in_valid held high during issue
    load(A2, B2, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_a = 8'h55;
    in_b = 8'hAA;
    chk("issue_ready", 32'({in_ready, out_valid}), 32'(2'b01));
    drain(64, -1, -1);
    in_valid = 1'b0;

    // abort mid-stream, then a fresh set
    load(A, B, 1'b0, 1'b0);
    drain(64, -1, 10);
    load(A2, B2, 1'b0, 1'b0);
    drain(64, -1, -1);

    // async reset after two bytes
    in_valid = 1'b1; in_a = 8'hAB; in_b = 8'hCD; mode = 1'b1;
    step();
    in_a = 8'h01; in_b = 8'h23;
    step();
    in_valid = 1'b0;
    chk("preload_busy", 32'({busy, in_ready}), 32'(2'b11));
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 32'({in_ready, out_valid, busy, done}), 32'(4'b1000));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    load(A, B, 1'b0, 1'b0);
    drain(64, -1, -1);

    // BYTES=1 build, both modes
    sa  = 8'h3C;
    sbv = 8'hA5;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          if (m == 0 || i == j)
            sb1.push_back({sa[4*i +: 4], sbv[4*j +: 4], 1'(i), 1'(j), 2'(i + j), 1'(i == 1 && j == 1)});
      s_in_valid = 1'b1; s_in_a = sa; s_in_b = sbv; s_mode = 1'(m);
      step();
      s_in_valid = 1'b0;
      chk("b1_issue", 32'({s_out_valid, s_in_ready, s_busy}), 32'(3'b101));
      s_out_ready = 1'b1;
      s_got = 0;
      s_fin = 1'b0;
      for (int c = 0; c < 40 && !s_fin; c++) begin
        if (s_out_valid && sb1.size() != 0) begin
          chk("b1_pair", 32'({s_dig_a, s_dig_b, s_idx_a, s_idx_b, s_weight, s_out_last}),
              32'(sb1.pop_front()));
          s_got++;
          s_lst = s_out_last;
          step();
          if (s_lst) begin
            chk("b1_done", 32'({s_done, s_out_valid, s_busy}), 32'(3'b101));
            s_fin = 1'b1;
          end
        end else begin
          step();
        end
      end
      s_out_ready = 1'b0;
      chk("b1_pair_count", 32'(s_got), 32'((m == 0) ? 4 : 2));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
